// File: rtl/hdlverifier_capture_pkg.sv
// Shared encodings for the multi-channel capture block: FSM states and trigger modes.
package hdlverifier_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_FULL = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_LEVEL     = 2'd0;
  localparam logic [1:0] TRIG_EDGE      = 2'd1;
  localparam logic [1:0] TRIG_PATTERN   = 2'd2;
  localparam logic [1:0] TRIG_IMMEDIATE = 2'd3;

endpackage

// File: rtl/hdlverifier_sdpram.sv
// Simple dual-port RAM, one clock; read data registered 1 cycle, old data on same-address collision.
// No backpressure: one write and one read accepted every cycle.
module hdlverifier_sdpram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds between reads; only the output register is cleared by reset.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hdlverifier_capture_data_mc.sv
// Multi-channel windowed capture into a tagged ring-buffer RAM; writes land 1 cycle after the sample, reads 1 cycle.
// No backpressure: samples are taken whenever clk_enable is high in PRE/POST; run low aborts.
module hdlverifier_capture_data_mc
  import hdlverifier_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data,
  input  logic                         trigger,
  input  logic [1:0]                   trigger_mode,
  input  logic [NUM_CH*DATA_WIDTH-1:0] trig_mask,
  input  logic [NUM_CH*DATA_WIDTH-1:0] trig_value,
  input  logic [ADDR_WIDTH-1:0]        trigger_pos,
  input  logic [ADDR_WIDTH-1:0]        number_of_windows,
  input  logic                         run,
  output logic                         ready_to_capture,
  output logic                         flag_full,
  output logic [ADDR_WIDTH:0]          captured_window_count,
  input  logic                         rd,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic [NUM_CH*DATA_WIDTH:0]   rd_data
);

  localparam int DW = NUM_CH * DATA_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam addr_t AW_L    = addr_t'(ADDR_WIDTH);
  localparam cnt_t  DEPTH_C = cnt_t'(1) << ADDR_WIDTH;

  state_t        state, state_nx;
  logic          run_d, run_rise, sample;
  logic          trig_prev, hit, armed;
  logic          take_smp, tag_smp, win_done, last_win;

  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_mask, cfg_value;
  addr_t         cfg_wmask, cfg_tp;
  cnt_t          cfg_nwin;

  addr_t         nw_in, wmask_in, tp_in;
  cnt_t          nwin_in;

  addr_t         base, wptr, pre_cnt, post_cnt;
  cnt_t          count, count_inc;

  logic          wr_en;
  addr_t         wr_addr;
  logic [DW:0]   wr_dat;

  assign run_rise  = run & ~run_d;
  assign sample    = clk_enable & run;
  assign armed     = (pre_cnt >= cfg_tp);
  assign count_inc = count + cnt_t'(1);
  assign last_win  = (count_inc == cfg_nwin);

  // Window geometry from the raw config, latched on the arm edge.
  always_comb begin
    nw_in    = (number_of_windows > AW_L) ? AW_L : number_of_windows;
    wmask_in = addr_t'((DEPTH_C >> nw_in) - cnt_t'(1));
    tp_in    = (trigger_pos > wmask_in) ? wmask_in : trigger_pos;
    nwin_in  = cnt_t'(1) << nw_in;
  end

  always_comb begin
    hit = 1'b0;
    case (cfg_mode)
      TRIG_LEVEL:     hit = trigger;
      TRIG_EDGE:      hit = trigger & ~trig_prev;
      TRIG_PATTERN:   hit = ((data ^ cfg_value) & cfg_mask) == '0;
      TRIG_IMMEDIATE: hit = 1'b1;
      default:        hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take_smp = 1'b0;
    tag_smp  = 1'b0;
    win_done = 1'b0;
    unique case (state)
      ST_IDLE: if (run_rise) state_nx = ST_PRE;
      ST_PRE: begin
        if (sample) begin
          take_smp = 1'b1;
          if (armed && hit) begin
            tag_smp = 1'b1;
            if (cfg_tp != cfg_wmask) state_nx = ST_POST;
            else                     win_done = 1'b1;
          end
        end
      end
      ST_POST: begin
        if (sample) begin
          take_smp = 1'b1;
          if (post_cnt == cfg_wmask - cfg_tp - addr_t'(1)) win_done = 1'b1;
        end
      end
      ST_FULL: state_nx = ST_FULL;
    endcase
    if (win_done) state_nx = last_win ? ST_FULL : ST_PRE;
    if (!run)     state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_d            <= 1'b0;
      trig_prev        <= 1'b0;
      cfg_mode         <= TRIG_LEVEL;
      cfg_mask         <= '0;
      cfg_value        <= '0;
      cfg_wmask        <= '0;
      cfg_tp           <= '0;
      cfg_nwin         <= '0;
      base             <= '0;
      wptr             <= '0;
      pre_cnt          <= '0;
      post_cnt         <= '0;
      count            <= '0;
      wr_en            <= 1'b0;
      wr_addr          <= '0;
      wr_dat           <= '0;
      ready_to_capture <= 1'b0;
      flag_full        <= 1'b0;
    end else begin
      run_d <= run;
      if (clk_enable) trig_prev <= trigger;

      if (run_rise) begin
        cfg_mode  <= trigger_mode;
        cfg_mask  <= trig_mask;
        cfg_value <= trig_value;
        cfg_wmask <= wmask_in;
        cfg_tp    <= tp_in;
        cfg_nwin  <= nwin_in;
        base      <= '0;
        wptr      <= '0;
        pre_cnt   <= '0;
        post_cnt  <= '0;
        count     <= '0;
      end else if (!run) begin
        count <= '0;
      end else if (win_done) begin
        count    <= count_inc;
        base     <= base + cfg_wmask + addr_t'(1);
        wptr     <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
      end else if (take_smp) begin
        wptr <= (wptr + addr_t'(1)) & cfg_wmask;
        // pre_cnt saturates at tp: it only has to answer "armed yet?".
        if (state == ST_PRE && pre_cnt < cfg_tp) pre_cnt <= pre_cnt + addr_t'(1);
        if (state == ST_POST) post_cnt <= post_cnt + addr_t'(1);
      end

      wr_en   <= take_smp;
      wr_addr <= base + wptr;
      wr_dat  <= {tag_smp, data};

      ready_to_capture <= (state == ST_PRE) || (state == ST_POST);
      flag_full        <= (state == ST_FULL);
    end
  end

  assign captured_window_count = count;

  hdlverifier_sdpram #(
    .WIDTH (DW + 1),
    .DEPTH (2 ** ADDR_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_dat),
    .re    (rd),
    .raddr (raddr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_hdlverifier_capture_data_mc.sv
// Bench for hdlverifier_capture_data_mc: sample-level reference model plus readback scoreboard.
module tb_hdlverifier_capture_data_mc;

  localparam int DWID  = 8;
  localparam int NCH   = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int DW    = DWID * NCH;

  logic           clk = 1'b0;
  logic           reset, clk_enable, trigger, run, rd;
  logic [DW-1:0]  data, trig_mask, trig_value;
  logic [1:0]     trigger_mode;
  logic [AW-1:0]  trigger_pos, number_of_windows, raddr;
  logic           ready_to_capture, flag_full;
  logic [AW:0]    captured_window_count;
  logic [DW:0]    rd_data;

  always #5 clk = ~clk;

  hdlverifier_capture_data_mc #(
    .DATA_WIDTH (DWID),
    .NUM_CH     (NCH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .clk_enable            (clk_enable),
    .data                  (data),
    .trigger               (trigger),
    .trigger_mode          (trigger_mode),
    .trig_mask             (trig_mask),
    .trig_value            (trig_value),
    .trigger_pos           (trigger_pos),
    .number_of_windows     (number_of_windows),
    .run                   (run),
    .ready_to_capture      (ready_to_capture),
    .flag_full             (flag_full),
    .captured_window_count (captured_window_count),
    .rd                    (rd),
    .raddr                 (raddr),
    .rd_data               (rd_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: phase 0 idle, 1 pre, 2 post, 3 full.
  int          m_phase = 0, m_win = 0, m_w = 1, m_tp = 0, m_nw = 1;
  int          m_wp = 0, m_pre = 0, m_post = 0;
  logic        m_prev = 1'b0, m_run_d = 1'b0;
  logic [1:0]  m_mode = 2'd0;
  logic [DW-1:0] m_mask = '0, m_val = '0;
  logic [DW:0] m_mem [DEPTH];
  logic [DW:0] sb_q [$];

  task automatic m_complete();
    m_win++;
    if (m_win == m_nw) m_phase = 3;
    else begin
      m_phase = 1; m_wp = 0; m_pre = 0; m_post = 0;
    end
  endtask

  task automatic model_update();
    logic hit, tag;
    int   a, nw;
    if (reset) begin
      m_phase = 0; m_win = 0; m_prev = 1'b0; m_run_d = 1'b0;
      return;
    end
    case (m_mode)
      2'd0:    hit = trigger;
      2'd1:    hit = trigger && !m_prev;
      2'd2:    hit = ((data & m_mask) == (m_val & m_mask));
      default: hit = 1'b1;
    endcase
    if (clk_enable) m_prev = trigger;
    if (!run) begin
      m_phase = 0; m_win = 0;
    end else if (m_phase == 0) begin
      if (!m_run_d) begin
        nw     = (int'(number_of_windows) > AW) ? AW : int'(number_of_windows);
        m_w    = DEPTH >> nw;
        m_nw   = 1 << nw;
        m_tp   = (int'(trigger_pos) > m_w - 1) ? m_w - 1 : int'(trigger_pos);
        m_mode = trigger_mode; m_mask = trig_mask; m_val = trig_value;
        m_phase = 1; m_win = 0; m_wp = 0; m_pre = 0; m_post = 0;
      end
    end else if (clk_enable && m_phase != 3) begin
      a   = m_win * m_w + m_wp;
      tag = (m_phase == 1) && (m_pre >= m_tp) && hit;
      m_mem[a] = {tag, data};
      m_wp = (m_wp + 1) % m_w;
      if (m_phase == 1) begin
        if (tag) begin
          if (m_tp == m_w - 1) m_complete();
          else begin m_phase = 2; m_post = 0; end
        end else m_pre++;
      end else begin
        m_post++;
        if (m_post == m_w - 1 - m_tp) m_complete();
      end
    end
    m_run_d = run;
  endtask

  // One clock: advance the model with the inputs now on the pins, then check status.
  task automatic step();
    int old_phase;
    old_phase = reset ? 0 : m_phase;
    model_update();
    @(posedge clk); #1;
    chk("count", captured_window_count, m_win);
    chk("flag_full", flag_full, old_phase == 3);
    chk("ready", ready_to_capture, old_phase == 1 || old_phase == 2);
  endtask

  task automatic arm(input logic [1:0] mode, input int tp, input int nw,
                     input logic [DW-1:0] mask, input logic [DW-1:0] val);
    clk_enable = 1'b0; trigger = 1'b0; data = '0; rd = 1'b0;
    run = 1'b0; step();
    trigger_mode = mode; trigger_pos = tp[AW-1:0]; number_of_windows = nw[AW-1:0];
    trig_mask = mask; trig_value = val;
    run = 1'b1; step();
    // Scramble the live config: the block must keep using the latched copy.
    trigger_mode = mode + 2'd1; trigger_pos = '0; number_of_windows = '0;
    trig_mask = ~mask; trig_value = ~val;
  endtask

  task automatic smp(input logic en, input logic trg, input logic [DW-1:0] d);
    clk_enable = en; trigger = trg; data = d;
    step();
  endtask

  task automatic readback(input string tag);
    clk_enable = 1'b0; trigger = 1'b0; rd = 1'b0;
    step();
    for (int a = 0; a < DEPTH; a++) begin
      rd = 1'b1; raddr = a[AW-1:0];
      sb_q.push_back(m_mem[a]);
      step();
      chk(tag, rd_data, sb_q.pop_front());
    end
    rd = 1'b0; raddr = '0;
    step();
    chk({tag, "_hold"}, rd_data, m_mem[DEPTH-1]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    reset = 1'b1; clk_enable = 1'b0; trigger = 1'b0; run = 1'b0; rd = 1'b0;
    data = '0; trig_mask = '0; trig_value = '0; trigger_mode = '0;
    trigger_pos = '0; number_of_windows = '0; raddr = '0;
    step(); step();
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    step();

    // Single window, immediate trigger at tp=4.
    arm(2'd3, 4, 0, '0, '0);
    for (int k = 0; k < 16; k++) smp(1'b1, 1'b0, 16'(k));
    chk("t1_full_lag", flag_full, 0);
    smp(1'b0, 1'b0, '0);
    chk("t1_full", flag_full, 1);
    for (int k = 0; k < 3; k++) smp(1'b1, 1'b0, 16'hAAAA);
    readback("t1_rd");

    // Four windows, pattern trigger on the low byte.
    arm(2'd2, 1, 2, 16'h00FF, 16'h0005);
    for (int k = 0; k < 20; k++) smp(1'b1, 1'b0, {8'(8'hA0 + k), 8'(4 + k % 4)});
    chk("t2_count", captured_window_count, 4);
    readback("t2_rd");

    // Edge trigger with clk_enable gaps and trigger held high.
    arm(2'd1, 1, 2, '0, '0);
    for (int k = 0; k < 20; k++)
      smp(k % 2 == 0, (k >= 6 && k < 11), 16'(16'h3000 + k));
    chk("t3_count", captured_window_count, 1);
    readback("t3_rd");

    // Early level trigger ignored; tp clamps to W-1 so a hit ends the window.
    arm(2'd0, 9, 2, '0, '0);
    for (int k = 0; k < 12; k++)
      smp(1'b1, (k == 0 || k == 5 || k == 10), 16'(16'h5000 + k));
    chk("t4_count", captured_window_count, 2);
    readback("t4_rd");

    // W=1: window count clamps, every hit closes a window.
    arm(2'd3, 3, 7, '0, '0);
    for (int k = 0; k < 16; k++) smp(1'b1, 1'b0, 16'(16'h7000 + k));
    smp(1'b0, 1'b0, '0);
    chk("t5_count", captured_window_count, 16);
    chk("t5_full", flag_full, 1);
    readback("t5_rd");

    // Abort in POST together with a trigger, then re-arm to completion.
    arm(2'd3, 2, 0, '0, '0);
    for (int k = 0; k < 5; k++) smp(1'b1, 1'b0, 16'(16'h9000 + k));
    run = 1'b0;
    smp(1'b1, 1'b1, 16'h9999);
    chk("t6_abort_count", captured_window_count, 0);
    arm(2'd3, 2, 0, '0, '0);
    for (int k = 0; k < 16; k++) smp(1'b1, 1'b0, 16'(16'hB000 + k));
    smp(1'b0, 1'b0, '0);
    chk("t6_rearm_full", flag_full, 1);
    readback("t6_rd");

    // Reset mid-PRE clears every output.
    arm(2'd0, 5, 1, '0, '0);
    for (int k = 0; k < 3; k++) smp(1'b1, 1'b0, 16'(16'hC000 + k));
    reset = 1'b1;
    smp(1'b0, 1'b0, '0);
    chk("t7_rst_rd_data", rd_data, 0);
    chk("t7_rst_ready", ready_to_capture, 0);
    reset = 1'b0; run = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hdlverifier_capture_data_mc.md
# hdlverifier_capture_data_mc

Single-clock, multi-channel successor of the HDL Verifier data-capture block. It samples NUM_CH channels of DATA_WIDTH bits into a segmented ring-buffer RAM, with pre- and post-trigger depth per window. It supports four trigger modes and keeps a dedicated trigger-tag bit per entry, so no data bit is sacrificed. It sits between the user design and the JTAG/readout controller, and everything runs in the design clock domain.

## Interface
- DATA_WIDTH, 8, bits per channel
- NUM_CH, 2, channel count (≥1)
- ADDR_WIDTH, 6, log2 of RAM depth; DEPTH = 2**ADDR_WIDTH
- clk  in  1  design clock; one clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- clk_enable  in  1  sample qualifier; nothing is written when low
- data  in  NUM_CH*DATA_WIDTH  channel 0 in LSBs
- trigger  in  1  external trigger
- trigger_mode  in  2  0 level, 1 rising edge, 2 pattern, 3 immediate
- trig_mask  in  NUM_CH*DATA_WIDTH  pattern mask
- trig_value  in  NUM_CH*DATA_WIDTH  pattern value
- trigger_pos  in  ADDR_WIDTH  number of pre-trigger samples per window
- number_of_windows  in  ADDR_WIDTH  log2 of window count; values >ADDR_WIDTH clamp to ADDR_WIDTH
- run  in  1  arm; rising edge starts capture, low aborts
- ready_to_capture  out  1  high in PRE/POST
- flag_full  out  1  high in FULL
- captured_window_count  out  ADDR_WIDTH+1  completed windows
- rd  in  1  read strobe
- raddr  in  ADDR_WIDTH  physical RAM address
- rd_data  out  NUM_CH*DATA_WIDTH+1  {tag, data}; valid 1 cycle after rd

## Operation
- **Configuration latch:** all config inputs are latched on the run rising edge and held until the next arm.
- **Window geometry:** NW = 2**nw; W = DEPTH>>nw. Effective trigger position tp = min(trigger_pos, W-1). Window k occupies base k*W.
- **States:**
  - IDLE: a run rising edge goes to PRE; counters clear.
  - PRE: every enabled sample is written at base + wptr, with wptr wrapping modulo W. The trigger is armed once pre_cnt ≥ tp. An armed hit writes that sample with tag=1; the next state is POST if tp < W-1, otherwise the window completes.
  - POST: writes W-1-tp samples, then the window completes.
  - Window complete: count++. If count == NW go to FULL, else go to PRE with base += W and wptr, pre_cnt cleared.
  - FULL: holds until run is low.
- **run low** in any state: go to IDLE on the next edge. The RAM contents are kept, and captured_window_count is cleared.
- **Trigger hit** (only with clk_enable=1):
  - Mode 0: trigger=1.
  - Mode 1: trigger=1 and the previous enabled sample of trigger was 0. The edge register updates only on clk_enable.
  - Mode 2: (data & trig_mask) == (trig_value & trig_mask).
  - Mode 3: always true.
- **Tag bit:** tag=1 only on the trigger sample; all other entries have tag=0.
- **RAM read/write:** a read and a write to the same address in the same cycle returns the old data.
- **Arithmetic:** all counters are unsigned ADDR_WIDTH bits. Only count is ADDR_WIDTH+1 bits, so it can hold DEPTH.

## Timing
- **Reset values:** every output is 0 (ready_to_capture, flag_full, captured_window_count, rd_data). State is IDLE and all counters are 0.
- **Write latency:** a sample presented at edge n is written to RAM at edge n+1, because data, address and tag are registered once.
- **Status outputs:** ready_to_capture and flag_full are registered from state and lag it by 1 cycle. captured_window_count is registered.
- **Read latency:** 1 cycle. rd_data holds its value when rd=0.
- **Run edge:** a run rising edge at edge n puts the block in PRE from n+1. The sample at n+1 is the first one eligible for writing.
- **Simultaneous events:**
  - run low together with a trigger: abort wins.
  - reset overrides everything.
  - A trigger in PRE before pre_cnt ≥ tp is ignored.
- **W=1 case:** tp=0, and every hit completes a window.

## Structure
- **Package hdlverifier_capture_pkg:**
  - state encoding (IDLE, PRE, POST, FULL)
  - trigger-mode constants (TRIG_LEVEL, TRIG_EDGE, TRIG_PATTERN, TRIG_IMMEDIATE)
- **Sub-module hdlverifier_sdpram:** single-clock simple dual-port RAM with a registered, reset-cleared read output, parameterised on width and depth.
- **Top level:** FSM, trigger unit, address/counter logic and status registers.

## Test plan
- **Single window, immediate trigger.** Config: DW=8, NC=2, AW=4, nw=0, tp=4, mode 3, data=count. Expected: 16 samples are written, addr 4 has tag=1, and flag_full rises exactly after the 16th write; readback matches.
- **Four windows, pattern trigger.** Config: nw=2 (W=4), tp=1, mode 2, mask=0x00FF, value=0x0005. Expected: each window has 1 pre-sample, then the tagged 0x..05, then 2 post-samples; captured_window_count steps 1..4 and flag_full follows.
- **Edge trigger with gaps.** Config: mode 1 with clk_enable toggling and trigger held high 5 cycles. Expected: exactly one tag; no writes on disabled cycles.
- **Early trigger and boundary position.** Trigger before pre_cnt reaches tp: ignored, capture continues wrapping and the next armed hit is tagged. Config tp=W-1: the window completes on the hit with no POST.
- **Abort and reset mid-run.** Drop run in POST: IDLE next cycle, count=0, flag_full=0; re-arm completes normally. Assert reset mid-PRE: all outputs 0 next cycle.
